// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle signed/unsigned multiply (shift-add) and divide (restoring) unit, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to compute MUL/MULU in a single cycle; DIV is always iterative.
module iterative_muldiv_unit #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [W-1:0] reg1_i,
  input  logic [W-1:0] reg2_i,
  input  logic [4:0]   destination_i,
  input  logic [4:0]   destination2_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] result_o,
  output logic [W-1:0] result2_o,
  output logic [4:0]   destination_o,
  output logic [4:0]   destination2_o,
  output logic [2:0]   flags_o,
  output logic         flags_we_o
);

  localparam int unsigned CNT_W = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, neg_q, rneg_q, ov_q;
  logic [W-1:0]     opb_q;
  logic [2*W-1:0]   acc_q;
  logic [4:0]       dst_q, dst2_q;

  logic             ready_q, valid_q, flags_we_q;
  logic [W-1:0]     result_q, result2_q;
  logic [4:0]       dst_out_q, dst2_out_q;
  logic [2:0]       flags_q;

  logic             in_signed, in_div, in_ov;
  logic [W-1:0]     mag1, mag2;
  logic [W:0]       mul_sum, div_top, div_diff;
  logic [2*W-1:0]   acc_step, prod_fix;
  logic [W-1:0]     quo_fix, rem_fix;

  always_comb begin
    in_signed = ~op_i[0];
    in_div    = op_i[1];
    mag1      = (in_signed && reg1_i[W-1]) ? -reg1_i : reg1_i;
    mag2      = (in_signed && reg2_i[W-1]) ? -reg2_i : reg2_i;
    in_ov     = in_signed && in_div && (reg2_i == {1'b1, {(W-1){1'b0}}}) && (reg1_i == '1);
  end

  // acc_q holds {product-high, multiplier} for MUL and {partial remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_top  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff = div_top - {1'b0, opb_q};
    if (is_div_q) begin
      if (!div_diff[W])
        acc_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      else
        acc_step = {div_top[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[W-1:0] : acc_step[W-1:0];
    rem_fix  = rneg_q ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0] fast_s;
  logic        [2*W-1:0] fast_u, fast_prod;

  always_comb begin
    fast_s    = $signed(reg2_i) * $signed(reg1_i);
    fast_u    = {{W{1'b0}}, reg2_i} * {{W{1'b0}}, reg1_i};
    fast_prod = in_signed ? fast_s : fast_u;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      ov_q       <= 1'b0;
      opb_q      <= '0;
      acc_q      <= '0;
      dst_q      <= '0;
      dst2_q     <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      result_q   <= '0;
      result2_q  <= '0;
      dst_out_q  <= '0;
      dst2_out_q <= '0;
      flags_q    <= '0;
      flags_we_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= in_div;
            neg_q    <= in_signed && (reg1_i[W-1] ^ reg2_i[W-1]);
            rneg_q   <= in_signed && reg2_i[W-1];
            ov_q     <= in_ov;
            dst_q    <= destination_i;
            dst2_q   <= destination2_i;
            opb_q    <= in_div ? mag1 : mag2;
            acc_q    <= {{W{1'b0}}, (in_div ? mag2 : mag1)};
            if (in_div && (reg1_i == '0)) begin
              state_q    <= S_DONE;
              valid_q    <= 1'b1;
              result_q   <= '0;
              result2_q  <= reg2_i;
              flags_q    <= 3'b101;
              flags_we_q <= 1'b1;
              dst_out_q  <= destination_i;
              dst2_out_q <= destination2_i;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!in_div) begin
              state_q    <= S_DONE;
              valid_q    <= 1'b1;
              result_q   <= fast_prod[W-1:0];
              result2_q  <= fast_prod[2*W-1:W];
              flags_q    <= '0;
              flags_we_q <= 1'b0;
              dst_out_q  <= destination_i;
              dst2_out_q <= destination2_i;
            end
`endif
            else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CNT_W'(1);
          // final sign fix-up is folded into the last iteration so DONE is purely a strobe cycle
          if (cnt_q == CNT_W'(W - 1)) begin
            state_q    <= S_DONE;
            valid_q    <= 1'b1;
            dst_out_q  <= dst_q;
            dst2_out_q <= dst2_q;
            if (is_div_q) begin
              result_q   <= quo_fix;
              result2_q  <= rem_fix;
              flags_q    <= {ov_q, quo_fix[W-1], (quo_fix == '0)};
              flags_we_q <= 1'b1;
            end else begin
              result_q   <= prod_fix[W-1:0];
              result2_q  <= prod_fix[2*W-1:W];
              flags_q    <= '0;
              flags_we_q <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o        = ready_q;
  assign valid_o        = valid_q;
  assign result_o       = result_q;
  assign result2_o      = result2_q;
  assign destination_o  = dst_out_q;
  assign destination2_o = dst2_out_q;
  assign flags_o        = flags_q;
  assign flags_we_o     = flags_we_q;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Self-checking bench for iterative_muldiv_unit: directed corner cases plus randomized ops
// against an arithmetic reference model; honours MULDIV_FAST_MUL_EN for MUL latency.
module tb_iterative_muldiv_unit;
  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] reg1_i, reg2_i;
  logic [4:0]   destination_i, destination2_i;
  logic         ready_o, valid_o, flags_we_o;
  logic [W-1:0] result_o, result2_o;
  logic [4:0]   destination_o, destination2_o;
  logic [2:0]   flags_o;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  iterative_muldiv_unit #(.W(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i),
    .destination_i(destination_i), .destination2_i(destination2_i),
    .ready_o(ready_o), .valid_o(valid_o),
    .result_o(result_o), .result2_o(result2_o),
    .destination_o(destination_o), .destination2_o(destination2_o),
    .flags_o(flags_o), .flags_we_o(flags_we_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like the unit
  function automatic void model(input logic [1:0] op, input logic [31:0] r1, input logic [31:0] r2,
                                output logic [31:0] q, output logic [31:0] rm,
                                output logic [2:0] fl, output logic we);
    longint a, b, p, qq, rr;
    bit sgn;
    sgn = !op[0];
    a = sgn ? longint'($signed(r2)) : longint'({32'b0, r2});
    b = sgn ? longint'($signed(r1)) : longint'({32'b0, r1});
    if (!op[1]) begin
      p  = a * b;
      q  = p[31:0];
      rm = p[63:32];
      fl = 3'b000;
      we = 1'b0;
    end else begin
      we = 1'b1;
      if (r1 == 32'd0) begin
        q = 32'd0; rm = r2; fl = 3'b101;
      end else if (sgn && r2 == 32'h8000_0000 && r1 == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; rm = 32'd0; fl = 3'b110;
      end else begin
        qq = a / b;
        rr = a % b;
        q  = qq[31:0];
        rm = rr[31:0];
        fl = {1'b0, q[31], (q == 32'd0)};
      end
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("ready_wait", ready_o, 1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] d1, input logic [4:0] d2, input bit pulse);
    logic [31:0] eq, er;
    logic [2:0]  ef;
    logic        ew;
    int          n, exp_lat;
    model(op, r1, r2, eq, er, ef, ew);
    exp_lat = op[1] ? ((r1 == 32'd0) ? 1 : int'(W) + 1) : MUL_LAT;
    wait_ready();
    start_i = 1'b1; op_i = op; reg1_i = r1; reg2_i = r2;
    destination_i = d1; destination2_i = d2;
    @(negedge clk);
    start_i = 1'b0;
    n = 1;
    check_val("ready_busy", ready_o, 0);
    while (!valid_o && n < 80) begin
      if (pulse && n == 3) begin
        start_i = 1'b1; op_i = ~op; reg1_i = $urandom; reg2_i = $urandom;
        destination_i = ~d1; destination2_i = ~d2;
      end else if (n == 4) begin
        start_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    check_val("latency", n, exp_lat);
    check_val("result", result_o, eq);
    check_val("result2", result2_o, er);
    check_val("flags", flags_o, ef);
    check_val("flags_we", flags_we_o, ew);
    check_val("dest", destination_o, d1);
    check_val("dest2", destination2_o, d2);
    @(negedge clk);
    check_val("valid_pulse", valid_o, 0);
    check_val("ready_back", ready_o, 1);
    check_val("hold", result_o, eq);
  endtask

  task automatic back_to_back(input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] eq, er;
    logic [2:0]  ef;
    logic        ew;
    int          n;
    model(2'b11, r1, r2, eq, er, ef, ew);
    wait_ready();
    start_i = 1'b1; op_i = 2'b11; reg1_i = r1; reg2_i = r2;
    destination_i = 5'd9; destination2_i = 5'd10;
    n = 0;
    while (!valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("b2b_first", valid_o, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n = 1;
      while (!valid_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_val("b2b_gap", n, W + 2);
      check_val("b2b_result", result_o, eq);
      check_val("b2b_result2", result2_o, er);
    end
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("b2b_stop", ready_o, 1);
  endtask

  task automatic reset_mid_div();
    int n, seen;
    wait_ready();
    start_i = 1'b1; op_i = 2'b10; reg1_i = 32'd3; reg2_i = 32'd1000;
    destination_i = 5'd3; destination2_i = 5'd4;
    @(negedge clk);
    start_i = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_ready", ready_o, 1);
    check_val("rst_valid", valid_o, 0);
    check_val("rst_result", result_o, 0);
    check_val("rst_we", flags_we_o, 0);
    seen = 0;
    for (int i = 0; i < int'(W) + 8; i++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    check_val("rst_no_valid", seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2;
    logic [1:0]  op;
    rst = 1'b1; start_i = 1'b0; op_i = '0; reg1_i = '0; reg2_i = '0;
    destination_i = '0; destination2_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("reset_ready", ready_o, 1);
    check_val("reset_valid", valid_o, 0);
    check_val("reset_res", {result2_o, result_o}, 64'd0);
    check_val("reset_misc", {destination_o, destination2_o, flags_o, flags_we_o}, 0);

    run_op(2'b10, 32'd7,          32'd100,        5'd5, 5'd6, 1'b0);
    run_op(2'b10, 32'd2,          32'hFFFF_FFF9,  5'd1, 5'd2, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFF,  32'h8000_0000,  5'd7, 5'd8, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  5'd7, 5'd0, 1'b0);
    run_op(2'b11, 32'd0,          32'h0000_1234,  5'd11, 5'd12, 1'b0);
    run_op(2'b10, 32'd0,          32'hFFFF_FF00,  5'd13, 5'd0, 1'b0);
    run_op(2'b00, 32'd2,          32'hFFFF_FFFF,  5'd14, 5'd15, 1'b0);
    run_op(2'b01, 32'd2,          32'hFFFF_FFFF,  5'd14, 5'd15, 1'b0);
    run_op(2'b10, 32'd13,         32'd12345,      5'd16, 5'd17, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      r1 = $urandom;
      r2 = $urandom;
      case ($urandom_range(0, 5))
        0: r1 = 32'd0;
        1: r1 = 32'($urandom_range(1, 20));
        2: begin r1 = 32'hFFFF_FFFF; r2 = 32'h8000_0000; end
        3: r2 = 32'($urandom_range(0, 50));
        default: ;
      endcase
      run_op(op, r1, r2, 5'($urandom), 5'($urandom), (op[1] && r1 != 32'd0) ? 1'b1 : 1'b0);
    end

    back_to_back(32'd9, 32'd1000);
    reset_mid_div();
    run_op(2'b10, 32'd7, 32'd100, 5'd5, 5'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
